// File: rtl/bingo_pkg.sv
// ---------------------------------------------------------------
// bingo_pkg : shared constants, phase encoding and line masks
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package bingo_pkg;

  localparam int BOARD_CELLS = 25;
  localparam int NUM_LINES   = 12;

  typedef enum logic [1:0] {
    PH_FILL  = 2'd0,
    PH_PLAY  = 2'd1,
    PH_COUNT = 2'd2,
    PH_WIN   = 2'd3
  } phase_e;

  // Scan order: rows 0-4, cols 0-4, main diagonal, anti-diagonal
  localparam logic [24:0] LINE_MASK [NUM_LINES] = '{
    25'h000001F, 25'h00003E0, 25'h0007C00, 25'h00F8000, 25'h1F00000,
    25'h0108421, 25'h0210842, 25'h0421084, 25'h0842108, 25'h1084210,
    25'h1041041, 25'h0111110
  };

endpackage

`default_nettype wire

// File: rtl/bingo_board_tracker_decode.sv
// ---------------------------------------------------------------
// bcd_pick_decode : two-digit BCD to binary, valid only for 1..25
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bcd_pick_decode (
  input  logic [7:0] bcd_i,
  output logic [4:0] value_o,
  output logic       valid_o
);

  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] bin;

  always_comb begin
    tens    = bcd_i[7:4];
    ones    = bcd_i[3:0];
    bin     = ({3'b000, tens} * 7'd10) + {3'b000, ones};
    value_o = bin[4:0];
    valid_o = (tens <= 4'd9) && (ones <= 4'd9) && (bin != 7'd0) && (bin <= 7'd25);
  end

endmodule

`default_nettype wire

// File: rtl/bingo_board_tracker.sv
// ---------------------------------------------------------------
// bingo_board_tracker : 5x5 bingo board fill, pick/mark and line scan
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bingo_board_tracker
  import bingo_pkg::*;
#(
  parameter int WIN_LINES  = 5,
  parameter bit FIRST_TURN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        interboard_rst_i,
  input  logic [7:0]  display_num_i,
  input  logic        enter_pulse_i,
  input  logic [4:0]  remote_num_i,
  input  logic        remote_valid_i,
  output logic [1:0]  phase_o,
  output logic [4:0]  fill_idx_o,
  output logic [24:0] mark_mask_o,
  output logic [3:0]  line_count_o,
  output logic        win_o,
  output logic        my_turn_o,
  output logic [4:0]  pick_num_o,
  output logic        pick_valid_o,
  output logic        err_pulse_o
);

  phase_e      phase_q, phase_d;
  logic [4:0]  fill_idx_q, fill_idx_d;
  logic [24:0] mark_q, mark_d;
  logic [24:0] used_q, used_d;
  logic [4:0]  pos_q [BOARD_CELLS];
  logic [4:0]  pos_d [BOARD_CELLS];
  logic [3:0]  line_count_q, line_count_d;
  logic        win_q, win_d;
  logic        my_turn_q, my_turn_d;
  logic [4:0]  pick_num_q, pick_num_d;
  logic        pick_valid_q, pick_valid_d;
  logic        err_q, err_d;
  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_num_q, buf_num_d;
  logic [3:0]  scan_idx_q, scan_idx_d;
  logic [3:0]  acc_q, acc_d;

  logic [4:0]  loc_v;
  logic        loc_ok;
  logic [4:0]  loc_idx;
  logic [4:0]  loc_cell;
  logic [4:0]  rem_num;
  logic        rem_ok;
  logic [4:0]  rem_idx;
  logic [4:0]  rem_cell;
  logic        hit;
  logic [3:0]  total;

  bcd_pick_decode u_decode (
    .bcd_i   (display_num_i),
    .value_o (loc_v),
    .valid_o (loc_ok)
  );

  // A buffered remote pick always takes precedence over a fresh strobe
  always_comb begin
    rem_num  = buf_valid_q ? buf_num_q : remote_num_i;
    rem_ok   = (rem_num != 5'd0) && (rem_num <= 5'd25);
    loc_idx  = loc_v - 5'd1;
    rem_idx  = rem_num - 5'd1;
    loc_cell = '0;
    rem_cell = '0;
    for (int i = 0; i < BOARD_CELLS; i++) begin
      if (loc_idx == 5'(i)) loc_cell = pos_q[i];
      if (rem_idx == 5'(i)) rem_cell = pos_q[i];
    end
    hit   = ((mark_q & LINE_MASK[scan_idx_q]) == LINE_MASK[scan_idx_q]);
    total = acc_q + {3'b000, hit};
  end

  always_comb begin
    phase_d      = phase_q;
    fill_idx_d   = fill_idx_q;
    mark_d       = mark_q;
    used_d       = used_q;
    pos_d        = pos_q;
    line_count_d = line_count_q;
    win_d        = win_q;
    my_turn_d    = my_turn_q;
    pick_num_d   = pick_num_q;
    pick_valid_d = 1'b0;
    err_d        = 1'b0;
    buf_valid_d  = buf_valid_q;
    buf_num_d    = buf_num_q;
    scan_idx_d   = scan_idx_q;
    acc_d        = acc_q;

    unique case (phase_q)
      PH_FILL: begin
        if (enter_pulse_i) begin
          if (!loc_ok || used_q[loc_idx]) begin
            err_d = 1'b1;
          end else begin
            pos_d[loc_idx]  = fill_idx_q;
            used_d[loc_idx] = 1'b1;
            fill_idx_d      = fill_idx_q + 5'd1;
            if (fill_idx_q == 5'd24) begin
              phase_d   = PH_PLAY;
              my_turn_d = FIRST_TURN;
            end
          end
        end
        if (remote_valid_i) begin
          if (buf_valid_q) begin
            err_d = 1'b1;
          end else begin
            buf_valid_d = 1'b1;
            buf_num_d   = remote_num_i;
          end
        end
      end

      PH_PLAY: begin
        if (buf_valid_q || remote_valid_i) begin
          // A fresh strobe arriving as the buffer drains simply refills it
          if (buf_valid_q) begin
            if (remote_valid_i) buf_num_d = remote_num_i;
            else                buf_valid_d = 1'b0;
          end
          if (rem_ok) begin
            mark_d[rem_cell] = 1'b1;
            my_turn_d        = 1'b1;
            phase_d          = PH_COUNT;
          end else begin
            err_d = 1'b1;
          end
          if (enter_pulse_i) err_d = 1'b1;
        end else if (enter_pulse_i) begin
          if (!my_turn_q || !loc_ok || mark_q[loc_cell]) begin
            err_d = 1'b1;
          end else begin
            mark_d[loc_cell] = 1'b1;
            pick_num_d       = loc_v;
            pick_valid_d     = 1'b1;
            my_turn_d        = 1'b0;
            phase_d          = PH_COUNT;
          end
        end
      end

      PH_COUNT: begin
        if (scan_idx_q == 4'(NUM_LINES - 1)) begin
          line_count_d = total;
          win_d        = (int'(total) >= WIN_LINES);
          phase_d      = (int'(total) >= WIN_LINES) ? PH_WIN : PH_PLAY;
          scan_idx_d   = '0;
          acc_d        = '0;
        end else begin
          scan_idx_d = scan_idx_q + 4'd1;
          acc_d      = total;
        end
        if (enter_pulse_i) err_d = 1'b1;
        if (remote_valid_i) begin
          if (buf_valid_q) begin
            err_d = 1'b1;
          end else begin
            buf_valid_d = 1'b1;
            buf_num_d   = remote_num_i;
          end
        end
      end

      PH_WIN: begin
        if (enter_pulse_i) err_d = 1'b1;
      end

      default: phase_d = PH_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || interboard_rst_i) begin
      phase_q      <= PH_FILL;
      fill_idx_q   <= '0;
      mark_q       <= '0;
      used_q       <= '0;
      for (int i = 0; i < BOARD_CELLS; i++) pos_q[i] <= '0;
      line_count_q <= '0;
      win_q        <= 1'b0;
      my_turn_q    <= 1'b0;
      pick_num_q   <= '0;
      pick_valid_q <= 1'b0;
      err_q        <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_num_q    <= '0;
      scan_idx_q   <= '0;
      acc_q        <= '0;
    end else begin
      phase_q      <= phase_d;
      fill_idx_q   <= fill_idx_d;
      mark_q       <= mark_d;
      used_q       <= used_d;
      pos_q        <= pos_d;
      line_count_q <= line_count_d;
      win_q        <= win_d;
      my_turn_q    <= my_turn_d;
      pick_num_q   <= pick_num_d;
      pick_valid_q <= pick_valid_d;
      err_q        <= err_d;
      buf_valid_q  <= buf_valid_d;
      buf_num_q    <= buf_num_d;
      scan_idx_q   <= scan_idx_d;
      acc_q        <= acc_d;
    end
  end

  assign phase_o      = phase_q;
  assign fill_idx_o   = fill_idx_q;
  assign mark_mask_o  = mark_q;
  assign line_count_o = line_count_q;
  assign win_o        = win_q;
  assign my_turn_o    = my_turn_q;
  assign pick_num_o   = pick_num_q;
  assign pick_valid_o = pick_valid_q;
  assign err_pulse_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bingo_board_tracker.sv
// ---------------------------------------------------------------
// tb_bingo_board_tracker : directed self-checking bench
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_bingo_board_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        interboard_rst_i = 1'b0;
  logic [7:0]  display_num_i = 8'h00;
  logic        enter_pulse_i = 1'b0;
  logic [4:0]  remote_num_i = 5'd0;
  logic        remote_valid_i = 1'b0;
  logic [1:0]  phase_o;
  logic [4:0]  fill_idx_o;
  logic [24:0] mark_mask_o;
  logic [3:0]  line_count_o;
  logic        win_o;
  logic        my_turn_o;
  logic [4:0]  pick_num_o;
  logic        pick_valid_o;
  logic        err_pulse_o;

  int total = 0;
  int bad   = 0;

  bingo_board_tracker #(.WIN_LINES(5), .FIRST_TURN(1'b1)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .interboard_rst_i (interboard_rst_i),
    .display_num_i    (display_num_i),
    .enter_pulse_i    (enter_pulse_i),
    .remote_num_i     (remote_num_i),
    .remote_valid_i   (remote_valid_i),
    .phase_o          (phase_o),
    .fill_idx_o       (fill_idx_o),
    .mark_mask_o      (mark_mask_o),
    .line_count_o     (line_count_o),
    .win_o            (win_o),
    .my_turn_o        (my_turn_o),
    .pick_num_o       (pick_num_o),
    .pick_valid_o     (pick_valid_o),
    .err_pulse_o      (err_pulse_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic enter(input logic [7:0] d);
    display_num_i = d;
    enter_pulse_i = 1'b1;
    step();
    enter_pulse_i = 1'b0;
  endtask

  task automatic remote(input logic [4:0] n);
    remote_num_i   = n;
    remote_valid_i = 1'b1;
    step();
    remote_valid_i = 1'b0;
  endtask

  task automatic fill_board();
    for (int n = 1; n <= 25; n++) enter(bcd(n));
  endtask

  task automatic test_reset();
    step();
    do_reset();
    total++;
    if ({phase_o, fill_idx_o, mark_mask_o, line_count_o, win_o, my_turn_o,
         pick_num_o, pick_valid_o, err_pulse_o} !== 45'd0) begin
      bad++; $display("FAIL reset_outputs: got phase=%0d fill=%0d mask=%h lc=%0d", phase_o, fill_idx_o, mark_mask_o, line_count_o);
    end
  endtask

  task automatic test_fill_errors();
    do_reset();
    enter(8'h07);
    total++; if (err_pulse_o !== 1'b0 || fill_idx_o !== 5'd1) begin
      bad++; $display("FAIL fill_first: err=%0b fill=%0d want err=0 fill=1", err_pulse_o, fill_idx_o); end
    enter(8'h07);
    total++; if (err_pulse_o !== 1'b1 || fill_idx_o !== 5'd1) begin
      bad++; $display("FAIL fill_dup: err=%0b fill=%0d want err=1 fill=1", err_pulse_o, fill_idx_o); end
    enter(8'h26);
    total++; if (err_pulse_o !== 1'b1) begin
      bad++; $display("FAIL fill_26: err=%0b want 1", err_pulse_o); end
    enter(8'h1A);
    total++; if (err_pulse_o !== 1'b1 || fill_idx_o !== 5'd1) begin
      bad++; $display("FAIL fill_1A: err=%0b fill=%0d want err=1 fill=1", err_pulse_o, fill_idx_o); end
    enter(8'h00);
    total++; if (err_pulse_o !== 1'b1) begin
      bad++; $display("FAIL fill_00: err=%0b want 1", err_pulse_o); end
    enter(8'h25);
    total++; if (err_pulse_o !== 1'b0 || fill_idx_o !== 5'd2 || phase_o !== 2'd0) begin
      bad++; $display("FAIL fill_25: err=%0b fill=%0d phase=%0d want 0/2/0", err_pulse_o, fill_idx_o, phase_o); end
  endtask

  task automatic test_fill_and_invalid_play();
    do_reset();
    fill_board();
    total++; if (phase_o !== 2'd1 || fill_idx_o !== 5'd25 || my_turn_o !== 1'b1) begin
      bad++; $display("FAIL fill_done: phase=%0d fill=%0d turn=%0b want 1/25/1", phase_o, fill_idx_o, my_turn_o); end
    enter(8'h99);
    total++; if (err_pulse_o !== 1'b1 || phase_o !== 2'd1 || mark_mask_o !== 25'd0) begin
      bad++; $display("FAIL play_99: err=%0b phase=%0d mask=%h want 1/1/0", err_pulse_o, phase_o, mark_mask_o); end
    remote(5'd0);
    total++; if (err_pulse_o !== 1'b1 || phase_o !== 2'd1 || mark_mask_o !== 25'd0) begin
      bad++; $display("FAIL remote_0: err=%0b phase=%0d mask=%h want 1/1/0", err_pulse_o, phase_o, mark_mask_o); end
    remote(5'd27);
    total++; if (err_pulse_o !== 1'b1 || phase_o !== 2'd1) begin
      bad++; $display("FAIL remote_27: err=%0b phase=%0d want 1/1", err_pulse_o, phase_o); end
  endtask

  // Continues from a freshly filled board with my_turn=1
  task automatic test_local_pick();
    int off;
    enter(8'h01);
    total++; if (pick_valid_o !== 1'b1 || pick_num_o !== 5'd1 || mark_mask_o !== 25'h1
                 || my_turn_o !== 1'b0 || phase_o !== 2'd2) begin
      bad++; $display("FAIL pick_01: pv=%0b pn=%0d mask=%h turn=%0b phase=%0d", pick_valid_o, pick_num_o, mark_mask_o, my_turn_o, phase_o); end
    enter(8'h02);
    total++; if (err_pulse_o !== 1'b1 || pick_valid_o !== 1'b0 || phase_o !== 2'd2) begin
      bad++; $display("FAIL count_enter: err=%0b pv=%0b phase=%0d want 1/0/2", err_pulse_o, pick_valid_o, phase_o); end
    off = 0;
    for (int i = 2; i <= 11; i++) begin
      step();
      if (phase_o != 2'd2 || line_count_o != 4'd0) off++;
    end
    total++; if (off !== 0) begin
      bad++; $display("FAIL count_hold: cycles_off=%0d want 0", off); end
    step();
    total++; if (phase_o !== 2'd1 || line_count_o !== 4'd0 || my_turn_o !== 1'b0) begin
      bad++; $display("FAIL count_end: phase=%0d lc=%0d turn=%0b want 1/0/0", phase_o, line_count_o, my_turn_o); end
    enter(8'h03);
    total++; if (err_pulse_o !== 1'b1 || mark_mask_o !== 25'h1) begin
      bad++; $display("FAIL not_my_turn: err=%0b mask=%h want 1/0000001", err_pulse_o, mark_mask_o); end
  endtask

  task automatic test_remote_buffer();
    remote(5'd2);
    total++; if (phase_o !== 2'd2 || my_turn_o !== 1'b1 || mark_mask_o !== 25'h3) begin
      bad++; $display("FAIL remote_2: phase=%0d turn=%0b mask=%h want 2/1/0000003", phase_o, my_turn_o, mark_mask_o); end
    remote(5'd5);
    total++; if (err_pulse_o !== 1'b0) begin
      bad++; $display("FAIL buf_capture: err=%0b want 0", err_pulse_o); end
    remote(5'd6);
    total++; if (err_pulse_o !== 1'b1) begin
      bad++; $display("FAIL buf_full: err=%0b want 1", err_pulse_o); end
    for (int i = 3; i <= 12; i++) step();
    total++; if (phase_o !== 2'd1 || mark_mask_o !== 25'h3) begin
      bad++; $display("FAIL buf_wait: phase=%0d mask=%h want 1/0000003", phase_o, mark_mask_o); end
    step();
    total++; if (phase_o !== 2'd2 || mark_mask_o !== 25'h13 || my_turn_o !== 1'b1 || err_pulse_o !== 1'b0) begin
      bad++; $display("FAIL buf_consume: phase=%0d mask=%h turn=%0b err=%0b", phase_o, mark_mask_o, my_turn_o, err_pulse_o); end
  endtask

  task automatic test_interboard_reset();
    for (int i = 0; i < 4; i++) step();
    interboard_rst_i = 1'b1;
    step();
    interboard_rst_i = 1'b0;
    total++;
    if ({phase_o, fill_idx_o, mark_mask_o, line_count_o, win_o, my_turn_o,
         pick_num_o, pick_valid_o, err_pulse_o} !== 45'd0) begin
      bad++; $display("FAIL irst_outputs: phase=%0d fill=%0d mask=%h turn=%0b pn=%0d", phase_o, fill_idx_o, mark_mask_o, my_turn_o, pick_num_o); end
    step();
    total++; if (phase_o !== 2'd0 || fill_idx_o !== 5'd0) begin
      bad++; $display("FAIL irst_hold: phase=%0d fill=%0d want 0/0", phase_o, fill_idx_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    fill_board();
    display_num_i  = 8'h04;
    enter_pulse_i  = 1'b1;
    remote_num_i   = 5'd5;
    remote_valid_i = 1'b1;
    step();
    enter_pulse_i  = 1'b0;
    remote_valid_i = 1'b0;
    total++; if (err_pulse_o !== 1'b1 || mark_mask_o !== 25'h10 || my_turn_o !== 1'b1
                 || pick_valid_o !== 1'b0 || phase_o !== 2'd2) begin
      bad++; $display("FAIL simult: err=%0b mask=%h turn=%0b pv=%0b phase=%0d", err_pulse_o, mark_mask_o, my_turn_o, pick_valid_o, phase_o); end
  endtask

  task automatic test_win();
    int exp_lc;
    logic [3:0] prev_lc;
    do_reset();
    fill_board();
    total++; if (mark_mask_o !== 25'd0) begin
      bad++; $display("FAIL win_start_mask: mask=%h want 0", mark_mask_o); end
    for (int c = 0; c <= 20; c++) begin
      prev_lc = line_count_o;
      if (c % 2 == 0) enter(bcd(c + 1));
      else            remote(5'(c + 1));
      for (int k = 1; k <= 11; k++) step();
      if (c == 4 || c == 20) begin
        total++; if (line_count_o !== prev_lc) begin
          bad++; $display("FAIL lc_latency c=%0d: lc=%0d want %0d", c, line_count_o, prev_lc); end
      end
      step();
      if (c == 4 || c == 9 || c == 14 || c == 19) begin
        exp_lc = (c + 1) / 5;
        total++; if (line_count_o !== 4'(exp_lc) || phase_o !== 2'd1 || win_o !== 1'b0) begin
          bad++; $display("FAIL lc_row c=%0d: lc=%0d phase=%0d win=%0b want %0d/1/0", c, line_count_o, phase_o, win_o, exp_lc); end
      end
    end
    // cell 20 closes column 0 and the anti-diagonal on top of four rows
    total++; if (line_count_o !== 4'd6 || win_o !== 1'b1 || phase_o !== 2'd3 || mark_mask_o !== 25'h01FFFFF) begin
      bad++; $display("FAIL win: lc=%0d win=%0b phase=%0d mask=%h want 6/1/3/01fffff", line_count_o, win_o, phase_o, mark_mask_o); end
    enter(bcd(22));
    total++; if (err_pulse_o !== 1'b1 || phase_o !== 2'd3 || mark_mask_o !== 25'h01FFFFF) begin
      bad++; $display("FAIL win_enter: err=%0b phase=%0d mask=%h want 1/3/01fffff", err_pulse_o, phase_o, mark_mask_o); end
    remote(5'd23);
    step();
    total++; if (phase_o !== 2'd3 || mark_mask_o !== 25'h01FFFFF || line_count_o !== 4'd6) begin
      bad++; $display("FAIL win_hold: phase=%0d mask=%h lc=%0d want 3/01fffff/6", phase_o, mark_mask_o, line_count_o); end
  endtask

  initial begin
    test_reset();
    test_fill_errors();
    test_fill_and_invalid_play();
    test_local_pick();
    test_remote_buffer();
    test_interboard_reset();
    test_simultaneous();
    test_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
